// File: rtl/commit_trace_stage.sv
// Commit-side trace stage: registers the writeback record for the trace sink, counts retires, halts on invalid.
// Optional watchdog on a pipeline that stops retiring, enabled by defining COMMIT_TRACE_WDT_EN.
module commit_trace_stage #(
    parameter int unsigned WDT_LIMIT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_inst,
    input  logic [63:0] wb_dnpc,
    input  logic        wb_kill,
    input  logic        wb_invalid,
    output logic [31:0] trace_inst,
    output logic [63:0] trace_dnpc,
    output logic        trace_kill,
    output logic        trace_invalid,
    output logic        trace_en,
    output logic [63:0] retire_count,
    output logic        halted,
    output logic        wdt_timeout
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    // Out-of-range limits elaborate this empty marker block so they are easy to spot in a netlist.
    if ((WDT_LIMIT < 2) || (WDT_LIMIT > 1048576)) begin : g_wdt_limit_out_of_range
    end

    state_t      state_q, state_d;
    logic [31:0] trace_inst_q, trace_inst_d;
    logic [63:0] trace_dnpc_q, trace_dnpc_d;
    logic        trace_kill_q, trace_kill_d;
    logic        trace_invalid_q, trace_invalid_d;
    logic        trace_en_q, trace_en_d;
    logic [63:0] retire_count_q, retire_count_d;

    logic retire;
    logic halt_req;

    assign retire   = wb_valid & ~wb_kill & ~wb_invalid;
    assign halt_req = wb_valid & wb_invalid & ~wb_kill;

`ifdef COMMIT_TRACE_WDT_EN
    localparam int unsigned WDT_W = $clog2(WDT_LIMIT + 1);
    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_expire;

    // Expiry is the edge where the idle count would step onto the limit; a retire or halt on that edge wins.
    assign wdt_expire = (state_q == ST_RUN) & ~retire & ~halt_req
                      & (wdt_cnt_q == WDT_W'(WDT_LIMIT - 1));

    always_comb begin
        wdt_cnt_d = wdt_cnt_q;
        if (state_q == ST_RUN) begin
            wdt_cnt_d = retire ? '0 : wdt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wdt_cnt_q <= '0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
        end
    end

    assign wdt_timeout = (state_q == ST_TIMEOUT);
`else
    logic wdt_expire;
    assign wdt_expire  = 1'b0;
    assign wdt_timeout = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        trace_inst_d    = trace_inst_q;
        trace_dnpc_d    = trace_dnpc_q;
        trace_kill_d    = trace_kill_q;
        trace_invalid_d = trace_invalid_q;
        trace_en_d      = 1'b0;
        retire_count_d  = retire_count_q;
        case (state_q)
            ST_RUN: begin
                trace_en_d = wb_valid;
                if (wb_valid) begin
                    trace_inst_d    = wb_inst;
                    trace_dnpc_d    = wb_dnpc;
                    trace_kill_d    = wb_kill;
                    trace_invalid_d = wb_invalid;
                end
                if (retire) begin
                    retire_count_d = retire_count_q + 64'd1;
                end
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (wdt_expire) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
                // Terminal states: the payload holds and only reset leaves.
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_RUN;
            trace_inst_q    <= '0;
            trace_dnpc_q    <= '0;
            trace_kill_q    <= 1'b0;
            trace_invalid_q <= 1'b0;
            trace_en_q      <= 1'b0;
            retire_count_q  <= '0;
        end else begin
            state_q         <= state_d;
            trace_inst_q    <= trace_inst_d;
            trace_dnpc_q    <= trace_dnpc_d;
            trace_kill_q    <= trace_kill_d;
            trace_invalid_q <= trace_invalid_d;
            trace_en_q      <= trace_en_d;
            retire_count_q  <= retire_count_d;
        end
    end

    assign trace_inst    = trace_inst_q;
    assign trace_dnpc    = trace_dnpc_q;
    assign trace_kill    = trace_kill_q;
    assign trace_invalid = trace_invalid_q;
    assign trace_en      = trace_en_q;
    assign retire_count  = retire_count_q;
    assign halted        = (state_q == ST_HALTED);

endmodule

// File: tb/tb_commit_trace_stage.sv
// Bench for commit_trace_stage: directed vectors, a per-cycle behavioural model check and literal checkpoints.
module tb_commit_trace_stage;
    localparam int unsigned LIM = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_inst = '0;
    logic [63:0] wb_dnpc = '0;
    logic        wb_kill = 1'b0;
    logic        wb_invalid = 1'b0;
    logic [31:0] trace_inst;
    logic [63:0] trace_dnpc;
    logic        trace_kill;
    logic        trace_invalid;
    logic        trace_en;
    logic [63:0] retire_count;
    logic        halted;
    logic        wdt_timeout;

    always #5 clock = ~clock;

    commit_trace_stage #(.WDT_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_inst(wb_inst), .wb_dnpc(wb_dnpc),
        .wb_kill(wb_kill), .wb_invalid(wb_invalid),
        .trace_inst(trace_inst), .trace_dnpc(trace_dnpc), .trace_kill(trace_kill),
        .trace_invalid(trace_invalid), .trace_en(trace_en),
        .retire_count(retire_count), .halted(halted), .wdt_timeout(wdt_timeout)
    );

    // Model of the sink-visible state
    logic [31:0] m_inst;
    logic [63:0] m_dnpc;
    logic        m_kill, m_inv, m_en, m_halt, m_to;
    logic [63:0] m_count;
    int          m_idle;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            chk("trace_inst", {32'd0, trace_inst}, {32'd0, m_inst});
            chk("trace_dnpc", trace_dnpc, m_dnpc);
            chk("trace_kill", {63'd0, trace_kill}, {63'd0, m_kill});
            chk("trace_invalid", {63'd0, trace_invalid}, {63'd0, m_inv});
            chk("trace_en", {63'd0, trace_en}, {63'd0, m_en});
            chk("retire_count", retire_count, m_count);
            chk("halted", {63'd0, halted}, {63'd0, m_halt});
            chk("wdt_timeout", {63'd0, wdt_timeout}, {63'd0, m_to});
        end
    end

    // One clock: drive at negedge, advance the model with the same values at the posedge.
    task automatic cyc(input logic r, input logic v, input logic [31:0] i, input logic [63:0] d,
                       input logic k, input logic inv);
        bit ret, hlt;
        @(negedge clock);
        reset = r; wb_valid = v; wb_inst = i; wb_dnpc = d; wb_kill = k; wb_invalid = inv;
        @(posedge clock);
        ret = v && !k && !inv;
        hlt = v && inv && !k;
        if (r) begin
            m_inst = '0; m_dnpc = '0; m_kill = 0; m_inv = 0; m_en = 0;
            m_count = '0; m_halt = 0; m_to = 0; m_idle = 0;
        end else if (!m_halt && !m_to) begin
            m_en = v;
            if (v) begin
                m_inst = i; m_dnpc = d; m_kill = k; m_inv = inv;
            end
            if (ret) m_count = m_count + 64'd1;
            if (hlt) m_halt = 1'b1;
`ifdef COMMIT_TRACE_WDT_EN
            if (ret) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == LIM && !hlt) m_to = 1'b1;
            end
`endif
        end else begin
            m_en = 1'b0;
        end
        $display("cyc t=%0t rst=%0b v=%0b inst=%h dnpc=%h kill=%0b inv=%0b -> cnt=%0d", $time, r, v, i, d, k, inv, m_count);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cyc(1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic ret_i(input logic [31:0] i, input logic [63:0] d);
        cyc(1'b0, 1'b1, i, d, 1'b0, 1'b0);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h1234_5678, 64'd9, 1'b0, 1'b0);
        #1;
        chk("reset_en", {63'd0, trace_en}, 64'd0);
        chk("reset_cnt", retire_count, 64'd0);
        chk_on = 1'b1;

        // Three back-to-back retires
        ret_i(32'h0000_0013, 64'h8000_0004); #1;
        chk("t1_dnpc0", trace_dnpc, 64'h8000_0004);
        chk("t1_en0", {63'd0, trace_en}, 64'd1);
        ret_i(32'h0000_0013, 64'h8000_0008); #1;
        chk("t1_dnpc1", trace_dnpc, 64'h8000_0008);
        ret_i(32'h0000_0013, 64'h8000_000c); #1;
        chk("t1_dnpc2", trace_dnpc, 64'h8000_000c);
        chk("t1_inst2", {32'd0, trace_inst}, 64'h13);
        idle(1); #1;
        chk("t1_en_off", {63'd0, trace_en}, 64'd0);
        chk("t1_cnt", retire_count, 64'd3);

        // Kill between two retires
        cyc(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        ret_i(32'h0000_0093, 64'h8000_0100);
        cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 64'h8000_0104, 1'b1, 1'b0); #1;
        chk("t2_kill", {63'd0, trace_kill}, 64'd1);
        chk("t2_cnt_mid", retire_count, 64'd1);
        ret_i(32'h0000_0113, 64'h8000_0108); #1;
        chk("t2_cnt", retire_count, 64'd2);
        chk("t2_kill_clr", {63'd0, trace_kill}, 64'd0);

        // Invalid at cycle 10, ignored input at 12, then reset
        cyc(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        idle(9);
        cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 64'h8000_0200, 1'b0, 1'b1); #1;
        chk("t3_inv", {63'd0, trace_invalid}, 64'd1);
        chk("t3_halt", {63'd0, halted}, 64'd1);
        chk("t3_en", {63'd0, trace_en}, 64'd1);
        idle(1);
        ret_i(32'h0000_0013, 64'h8000_0204); #1;
        chk("t3_en_off", {63'd0, trace_en}, 64'd0);
        chk("t3_cnt", retire_count, 64'd0);
        chk("t3_hold", {32'd0, trace_inst}, 64'hFFFF_FFFF);
        cyc(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0); #1;
        chk("t3_rst_halt", {63'd0, halted}, 64'd0);
        chk("t3_rst_inst", {32'd0, trace_inst}, 64'd0);
        chk("t3_rst_dnpc", trace_dnpc, 64'd0);

        // Killed invalid is a plain kill
        cyc(1'b0, 1'b1, 32'h0000_FFFF, 64'h8000_0300, 1'b1, 1'b1); #1;
        chk("t4_halt", {63'd0, halted}, 64'd0);
        chk("t4_kill", {63'd0, trace_kill}, 64'd1);
        ret_i(32'h0000_0013, 64'h8000_0304); #1;
        chk("t4_cnt", retire_count, 64'd1);

        // Reset asserted with a valid input discards it
        ret_i(32'h0000_0013, 64'h8000_0308);
        cyc(1'b1, 1'b1, 32'h0000_0033, 64'h8000_030c, 1'b0, 1'b0); #1;
        chk("t5_en", {63'd0, trace_en}, 64'd0);
        chk("t5_cnt", retire_count, 64'd0);

        // Counter wrap from a preloaded value
        cyc(1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0); #1;
        force dut.retire_count_q = 64'hFFFF_FFFF_FFFF_FFFF;
        release dut.retire_count_q;
        m_count = 64'hFFFF_FFFF_FFFF_FFFF;
        ret_i(32'h0000_0013, 64'h8000_0400); #1;
        chk("t6_wrap0", retire_count, 64'd0);
        ret_i(32'h0000_0013, 64'h8000_0404); #1;
        chk("t6_wrap1", retire_count, 64'd1);

`ifdef COMMIT_TRACE_WDT_EN
        cyc(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        idle(LIM - 1); #1;
        chk("w_pre", {63'd0, wdt_timeout}, 64'd0);
        idle(1); #1;
        chk("w_fire", {63'd0, wdt_timeout}, 64'd1);
        ret_i(32'h0000_0013, 64'h8000_0500); #1;
        chk("w_frozen_en", {63'd0, trace_en}, 64'd0);
        chk("w_frozen_cnt", retire_count, 64'd0);
        cyc(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        idle(LIM - 2);
        ret_i(32'h0000_0013, 64'h8000_0600); #1;
        chk("w_retire15", {63'd0, wdt_timeout}, 64'd0);
        idle(LIM - 1); #1;
        chk("w_restart_pre", {63'd0, wdt_timeout}, 64'd0);
        idle(1); #1;
        chk("w_restart_fire", {63'd0, wdt_timeout}, 64'd1);
        cyc(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        idle(LIM - 1);
        cyc(1'b0, 1'b1, 32'hFFFF_0000, 64'h8000_0700, 1'b0, 1'b1); #1;
        chk("w_inv_halt", {63'd0, halted}, 64'd1);
        chk("w_inv_noto", {63'd0, wdt_timeout}, 64'd0);
`else
        cyc(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        idle(5000); #1;
        chk("nowdt_to", {63'd0, wdt_timeout}, 64'd0);
        ret_i(32'h0000_0013, 64'h8000_0800); #1;
        chk("nowdt_run_en", {63'd0, trace_en}, 64'd1);
        chk("nowdt_run_cnt", retire_count, 64'd1);
`endif

        @(negedge clock);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
